// File: rtl/cache_set_controller.sv
// Cache set controller: tag lookup, victim choice, write-back,
// refill and allocate for one NUM_WAYS-way set.
module cache_set_controller #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reqValid,
  output logic reqReady,
  input  logic reqWrite,
  input  logic [ADDRESS_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWData,
  output logic respValid,
  input  logic respReady,
  output logic [DATA_WIDTH-1:0] respRData,
  output logic respHit,
  output logic errMultiHit,
  input  logic [NUM_WAYS*(ADDRESS_WIDTH-$clog2(BLOCK_SIZE))-1:0] wayTag,
  input  logic [NUM_WAYS-1:0] wayValid,
  input  logic [NUM_WAYS-1:0] wayDirty,
  input  logic [NUM_WAYS-1:0] wayExpired,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] wayAge,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] wayDataOut,
  output logic [NUM_WAYS-1:0] wayWEn,
  output logic [NUM_WAYS-1:0] wayAllocate,
  output logic [NUM_WAYS-1:0] wayAccessed,
  output logic [DATA_WIDTH-1:0] wayDataIn,
  output logic [ADDRESS_WIDTH-1:0] wayAddress,
  output logic [COUNTER_WIDTH-1:0] accessedWayAge,
  output logic memReqValid,
  input  logic memReqReady,
  output logic memReqWrite,
  output logic [ADDRESS_WIDTH-1:0] memReqAddr,
  output logic [DATA_WIDTH-1:0] memReqWData,
  input  logic memRespValid,
  input  logic [DATA_WIDTH-1:0] memRespRData
);
  localparam int OW = $clog2(BLOCK_SIZE);
  localparam int TW = ADDRESS_WIDTH - OW;
  localparam int IW = $clog2(NUM_WAYS);
  localparam int CW = COUNTER_WIDTH;
  localparam int DW = DATA_WIDTH;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WB        = 3'd2;
  localparam logic [2:0] FILL      = 3'd3;
  localparam logic [2:0] FILL_WAIT = 3'd4;
  localparam logic [2:0] ALLOC     = 3'd5;
  localparam logic [2:0] RESP      = 3'd6;

  localparam logic [NUM_WAYS-1:0] ONE = NUM_WAYS'(1);

  logic [2:0] state;
  logic wr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] rdata_q;
  logic hit_q;
  logic [IW-1:0] vic_q;

  logic [TW-1:0] tag_q;
  logic [NUM_WAYS-1:0] hitv;
  logic hitany;
  logic multi;
  logic [IW-1:0] hidx;
  logic [IW-1:0] vidx;
  logic [IW-1:0] sel;
  logic [CW-1:0] sel_age;
  logic [DW-1:0] sel_data;
  logic [TW-1:0] sel_tag;

  assign tag_q = addr_q[ADDRESS_WIDTH-1:OW];

  // Parallel tag compare; lowest matching way wins.
  always_comb begin
    hitv = '0;
    hidx = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      hitv[i] = wayValid[i] &&
                (wayTag[i*TW +: TW] == tag_q);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (hitv[i]) hidx = IW'(i);
    hitany = |hitv;
    multi  = (hitv & (hitv - ONE)) != '0;
  end

  // Victim: first invalid, else first expired, else oldest.
  always_comb begin
    logic inv_f;
    logic exp_f;
    logic [IW-1:0] inv_i;
    logic [IW-1:0] exp_i;
    logic [IW-1:0] age_i;
    logic [CW-1:0] best;
    inv_f = 1'b0;
    exp_f = 1'b0;
    inv_i = '0;
    exp_i = '0;
    age_i = '0;
    best  = wayAge[CW-1:0];
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!wayValid[i]) begin
        inv_f = 1'b1;
        inv_i = IW'(i);
      end
      if (wayExpired[i]) begin
        exp_f = 1'b1;
        exp_i = IW'(i);
      end
    end
    for (int i = 1; i < NUM_WAYS; i++)
      if (wayAge[i*CW +: CW] > best) begin
        best  = wayAge[i*CW +: CW];
        age_i = IW'(i);
      end
    vidx = inv_f ? inv_i : (exp_f ? exp_i : age_i);
  end

  // Fields of the way being touched this cycle.
  always_comb begin
    sel      = (state == LOOKUP) ? hidx : vic_q;
    sel_age  = wayAge[sel*CW +: CW];
    sel_data = wayDataOut[sel*DW +: DW];
    sel_tag  = wayTag[sel*TW +: TW];
  end

  // Per-state output decode.
  always_comb begin
    reqReady       = 1'b0;
    respValid      = 1'b0;
    errMultiHit    = 1'b0;
    wayWEn         = '0;
    wayAllocate    = '0;
    wayAccessed    = '0;
    wayDataIn      = '0;
    wayAddress     = '0;
    accessedWayAge = '0;
    memReqValid    = 1'b0;
    memReqWrite    = 1'b0;
    memReqAddr     = '0;
    memReqWData    = '0;
    unique case (1'b1)
      (state == IDLE): reqReady = rst_n;
      (state == LOOKUP): begin
        if (hitany) begin
          wayAccessed    = ONE << hidx;
          accessedWayAge = sel_age;
          errMultiHit    = multi;
          if (wr_q) begin
            wayWEn    = ONE << hidx;
            wayDataIn = wdata_q;
          end
        end
      end
      (state == WB): begin
        memReqValid = 1'b1;
        memReqWrite = 1'b1;
        memReqAddr  = {sel_tag, OW'(0)};
        memReqWData = sel_data;
      end
      (state == FILL): begin
        memReqValid = 1'b1;
        memReqAddr  = {tag_q, OW'(0)};
      end
      (state == ALLOC): begin
        wayAllocate    = ONE << vic_q;
        wayWEn         = ONE << vic_q;
        wayAccessed    = ONE << vic_q;
        wayAddress     = addr_q;
        accessedWayAge = sel_age;
        wayDataIn      = wr_q ? wdata_q : fill_q;
      end
      (state == RESP): respValid = 1'b1;
      default: ;
    endcase
  end

  assign respRData = rdata_q;
  assign respHit   = hit_q;

  // Request sequencing and captured request/response state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      vic_q   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (reqValid) begin
            wr_q    <= reqWrite;
            addr_q  <= reqAddr;
            wdata_q <= reqWData;
            state   <= LOOKUP;
          end
        end
        (state == LOOKUP): begin
          if (hitany) begin
            rdata_q <= wr_q ? wdata_q : sel_data;
            hit_q   <= 1'b1;
            state   <= RESP;
          end else begin
            vic_q <= vidx;
            hit_q <= 1'b0;
            if (wayValid[vidx] && wayDirty[vidx])
              state <= WB;
            else
              state <= wr_q ? ALLOC : FILL;
          end
        end
        (state == WB):
          if (memReqReady) state <= wr_q ? ALLOC : FILL;
        (state == FILL):
          if (memReqReady) state <= FILL_WAIT;
        (state == FILL_WAIT): begin
          if (memRespValid) begin
            fill_q <= memRespRData;
            state  <= ALLOC;
          end
        end
        (state == ALLOC): begin
          rdata_q <= wayDataIn;
          state   <= RESP;
        end
        (state == RESP):
          if (respReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_set_controller.sv
// Randomized scoreboard bench for cache_set_controller
// with a behavioural way/memory model.
module tb_cache_set_controller;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int OW = 5;
  localparam int TW = AW - OW;

  logic clk = 0;
  logic rst_n = 0;
  logic reqValid = 0, reqReady, reqWrite = 0;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqWData = '0;
  logic respValid, respReady = 0, respHit, errMultiHit;
  logic [DW-1:0] respRData;
  logic [NW*TW-1:0] wayTag;
  logic [NW-1:0] wayValid, wayDirty, wayExpired;
  logic [NW*CW-1:0] wayAge;
  logic [NW*DW-1:0] wayDataOut;
  logic [NW-1:0] wayWEn, wayAllocate, wayAccessed;
  logic [DW-1:0] wayDataIn;
  logic [AW-1:0] wayAddress;
  logic [CW-1:0] accessedWayAge;
  logic memReqValid, memReqReady = 0, memReqWrite;
  logic [AW-1:0] memReqAddr;
  logic [DW-1:0] memReqWData;
  logic memRespValid = 0;
  logic [DW-1:0] memRespRData = '0;

  cache_set_controller dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqWData(reqWData),
    .respValid(respValid), .respReady(respReady),
    .respRData(respRData), .respHit(respHit),
    .errMultiHit(errMultiHit),
    .wayTag(wayTag), .wayValid(wayValid),
    .wayDirty(wayDirty), .wayExpired(wayExpired),
    .wayAge(wayAge), .wayDataOut(wayDataOut),
    .wayWEn(wayWEn), .wayAllocate(wayAllocate),
    .wayAccessed(wayAccessed), .wayDataIn(wayDataIn),
    .wayAddress(wayAddress),
    .accessedWayAge(accessedWayAge),
    .memReqValid(memReqValid), .memReqReady(memReqReady),
    .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
    .memReqWData(memReqWData),
    .memRespValid(memRespValid),
    .memRespRData(memRespRData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [TW-1:0] mtag [NW];
  bit mval [NW];
  bit mdty [NW];
  bit mexp [NW];
  logic [CW-1:0] mage [NW];
  logic [DW-1:0] mdat [NW];

  always_comb begin
    wayTag = '0;
    wayValid = '0;
    wayDirty = '0;
    wayExpired = '0;
    wayAge = '0;
    wayDataOut = '0;
    for (int i = 0; i < NW; i++) begin
      wayTag[i*TW +: TW] = mtag[i];
      wayValid[i] = mval[i];
      wayDirty[i] = mdty[i];
      wayExpired[i] = mexp[i];
      wayAge[i*CW +: CW] = mage[i];
      wayDataOut[i*DW +: DW] = mdat[i];
    end
  end

  typedef struct packed {
    logic [NW-1:0] acc;
    logic [NW-1:0] wen;
    logic [NW-1:0] alc;
    logic [DW-1:0] din;
    logic [AW-1:0] waddr;
    logic [CW-1:0] age;
    logic multi;
  } strb_t;
  typedef struct packed {
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } memx_t;
  typedef struct packed {
    logic [DW-1:0] rd;
    logic hit;
  } resp_t;

  strb_t sq [$];
  memx_t mq [$];
  resp_t rq [$];

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expected strobes, memory traffic, response.
  task automatic predict(input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] fv);
    logic [TW-1:0] t;
    int hits [$];
    int v;
    strb_t s;
    memx_t m;
    resp_t r;
    t = a[AW-1:OW];
    for (int i = 0; i < NW; i++)
      if (mval[i] && mtag[i] == t) hits.push_back(i);
    s = '0;
    if (hits.size() > 0) begin
      v = hits[0];
      s.acc = NW'(1 << v);
      s.wen = wr ? NW'(1 << v) : '0;
      s.din = wr ? wd : '0;
      s.age = mage[v];
      s.multi = hits.size() > 1;
      sq.push_back(s);
      r.rd = wr ? wd : mdat[v];
      r.hit = 1'b1;
      rq.push_back(r);
    end else begin
      v = -1;
      for (int i = 0; i < NW; i++)
        if (v < 0 && !mval[i]) v = i;
      for (int i = 0; i < NW; i++)
        if (v < 0 && mexp[i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < NW; i++)
          if (mage[i] > mage[v]) v = i;
      end
      if (mval[v] && mdty[v]) begin
        m.wr = 1'b1;
        m.addr = {mtag[v], 5'b0};
        m.wd = mdat[v];
        mq.push_back(m);
      end
      if (!wr) begin
        m.wr = 1'b0;
        m.addr = {t, 5'b0};
        m.wd = '0;
        mq.push_back(m);
      end
      s.acc = NW'(1 << v);
      s.wen = s.acc;
      s.alc = s.acc;
      s.din = wr ? wd : fv;
      s.waddr = a;
      s.age = mage[v];
      sq.push_back(s);
      r.rd = wr ? wd : fv;
      r.hit = 1'b0;
      rq.push_back(r);
    end
  endtask

  // Memory model.
  int fixstall = -1;
  int fixrdel = -1;
  bit hold = 0;
  bit pend = 0;
  bit counting = 0;
  int stall = 0;
  int rdel = 0;
  logic [DW-1:0] fillv = '0;

  initial forever begin
    @(posedge clk);
    #1;
    memReqReady = 0;
    memRespValid = 0;
    if (pend) begin
      if (!hold) begin
        if (rdel == 0) begin
          memRespValid = 1;
          memRespRData = fillv;
          pend = 0;
        end else rdel--;
      end
    end else if (memReqValid) begin
      if (!counting) begin
        counting = 1;
        stall = fixstall >= 0 ? fixstall : int'($urandom_range(0, 3));
      end
      if (stall == 0) begin
        memReqReady = 1;
        counting = 0;
        if (!memReqWrite) begin
          pend = 1;
          rdel = fixrdel >= 0 ? fixrdel : int'($urandom_range(0, 2));
        end
      end else stall--;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    respReady = $urandom_range(0, 3) != 0;
  end

  // Monitors.
  strb_t ms;
  memx_t mm;
  resp_t mr;

  always @(negedge clk) if (rst_n) begin
    if (wayAccessed != 0) begin
      if (sq.size() == 0)
        chk("unexpected strobe", 64'(wayAccessed), 0);
      else begin
        ms = sq.pop_front();
        chk("wayAccessed", 64'(wayAccessed), 64'(ms.acc));
        chk("wayWEn", 64'(wayWEn), 64'(ms.wen));
        chk("wayAllocate", 64'(wayAllocate), 64'(ms.alc));
        chk("accessedWayAge", 64'(accessedWayAge), 64'(ms.age));
        chk("errMultiHit", 64'(errMultiHit), 64'(ms.multi));
        if (ms.wen != 0)
          chk("wayDataIn", 64'(wayDataIn), 64'(ms.din));
        if (ms.alc != 0)
          chk("wayAddress", 64'(wayAddress), 64'(ms.waddr));
      end
    end else begin
      chk("idle strobes", {wayWEn, wayAllocate, errMultiHit}, 0);
      chk("idle way data", {wayDataIn, wayAddress}, 0);
    end
  end

  always @(negedge clk) if (rst_n && memReqValid) begin
    if (mq.size() == 0)
      chk("unexpected memreq", 64'(memReqValid), 0);
    else begin
      mm = mq[0];
      chk("memReqWrite", 64'(memReqWrite), 64'(mm.wr));
      chk("memReqAddr", 64'(memReqAddr), 64'(mm.addr));
      if (mm.wr)
        chk("memReqWData", 64'(memReqWData), 64'(mm.wd));
      if (memReqReady) void'(mq.pop_front());
    end
  end

  always @(negedge clk) if (rst_n && respValid && respReady) begin
    if (rq.size() == 0)
      chk("unexpected resp", 64'(respValid), 0);
    else begin
      mr = rq.pop_front();
      chk("respRData", 64'(respRData), 64'(mr.rd));
      chk("respHit", 64'(respHit), 64'(mr.hit));
    end
  end

  // Driver.
  task automatic issue(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output int acc);
    bit ok;
    ok = 0;
    acc = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #1;
      reqValid = 1;
      reqWrite = wr;
      reqAddr = a;
      reqWData = wd;
      acc = cyc;
      @(negedge clk);
      ok = reqReady;
    end
    @(posedge clk);
    #1;
    reqValid = 0;
    if (!ok) chk("request accept timeout", 64'(ok), 1);
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] fv,
                         input int explat);
    int acc;
    int lat;
    fillv = fv;
    predict(wr, a, wd, fv);
    issue(wr, a, wd, acc);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (respValid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("response timeout", 64'(lat), 0);
    else if (explat >= 0) chk("latency", 64'(lat), 64'(explat));
    for (int k = 0; k < 400 && rq.size() != 0; k++)
      @(negedge clk);
    @(posedge clk);
    #1;
    chk("queues drained", 64'(rq.size() + sq.size() + mq.size()), 0);
  endtask

  task automatic set_way(input int i, input logic [TW-1:0] t,
                         input bit v, input bit d, input bit e,
                         input logic [CW-1:0] ag,
                         input logic [DW-1:0] dt);
    mtag[i] = t;
    mval[i] = v;
    mdty[i] = d;
    mexp[i] = e;
    mage[i] = ag;
    mdat[i] = dt;
  endtask

  int acc0;

  initial begin
    for (int i = 0; i < NW; i++)
      set_way(i, '0, 0, 0, 0, '0, '0);
    #2;
    chk("reset reqReady", 64'(reqReady), 0);
    chk("reset outputs",
        {respValid, memReqValid, wayAccessed, wayWEn, wayAllocate}, 0);
    #20;
    @(negedge clk);
    rst_n = 1;

    // Read hit in way 0.
    set_way(0, 27'h1234, 1, 0, 0, 8'd7, 32'h1111_2222);
    run_txn(0, 32'h1234 << 5, 32'h0, 32'h0, 2);

    // Write hit in way 2.
    set_way(1, 27'h10, 1, 1, 0, 8'd2, 32'h3);
    set_way(2, 27'h55, 1, 0, 0, 8'd4, 32'h4);
    set_way(3, 27'h77, 1, 0, 0, 8'd5, 32'h5);
    run_txn(1, {27'h55, 5'h4}, 32'hDEADBEEF, 32'h0, 2);

    // Clean read miss into invalid way 1, zero-wait memory.
    fixstall = 0;
    fixrdel = 0;
    set_way(0, 27'h20, 1, 1, 0, 8'd9, 32'h6);
    set_way(1, 27'h21, 0, 1, 0, 8'd9, 32'h7);
    set_way(2, 27'h22, 1, 1, 0, 8'd9, 32'h8);
    set_way(3, 27'h23, 1, 1, 0, 8'd9, 32'h9);
    run_txn(0, {27'h999, 5'h0}, 32'h0, 32'hA5A5A5A5, 5);

    // Dirty oldest victim with a stalled write-back.
    fixstall = 4;
    set_way(0, 27'h30, 1, 0, 0, 8'd3, 32'hA0);
    set_way(1, 27'h31, 1, 1, 0, 8'd9, 32'hA1);
    set_way(2, 27'h32, 1, 0, 0, 8'd9, 32'hA2);
    set_way(3, 27'h33, 1, 0, 0, 8'd1, 32'hA3);
    run_txn(0, {27'h444, 5'h0}, 32'h0, 32'h0BAD_F00D, -1);
    fixstall = -1;
    fixrdel = -1;

    // Two matching ways.
    set_way(1, 27'h66, 1, 0, 0, 8'd2, 32'hB1);
    set_way(3, 27'h66, 1, 0, 0, 8'd8, 32'hB3);
    run_txn(0, {27'h66, 5'h0}, 32'h0, 32'h0, 2);

    // Reset while waiting for refill data.
    hold = 1;
    for (int i = 0; i < NW; i++)
      set_way(i, 27'(i + 1), 1, 0, 0, 8'(i), 32'(i));
    fillv = 32'h7777_7777;
    predict(0, {27'h500, 5'h0}, 32'h0, fillv);
    issue(0, {27'h500, 5'h0}, 32'h0, acc0);
    for (int k = 0; k < 100 && mq.size() != 0; k++)
      @(negedge clk);
    @(posedge clk);
    #3;
    chk("in fill wait", 64'(memReqValid), 0);
    rst_n = 0;
    #1;
    chk("rst reqReady", 64'(reqReady), 0);
    chk("rst outputs",
        {respValid, memReqValid, wayAccessed, wayWEn, wayAllocate}, 0);
    chk("rst resp data", {respRData, 31'b0, respHit}, 0);
    sq.delete();
    rq.delete();
    mq.delete();
    hold = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #2;
    memRespValid = 1;
    memRespRData = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late memResp ignored", 64'(reqReady), 1);
    run_txn(1, {27'h600, 5'h0}, 32'h1357_9BDF, 32'h0, -1);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      for (int i = 0; i < NW; i++)
        set_way(i, 27'(27'h100 + $urandom_range(0, 5)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) != 0,
                $urandom_range(0, 9) == 0,
                8'($urandom_range(0, 15)),
                $urandom);
      run_txn($urandom_range(0, 1) != 0,
              {27'(27'h100 + $urandom_range(0, 6)), 5'($urandom)},
              $urandom, $urandom, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/cache_set_controller.md
Name: cache_set_controller

Overview:
- Sequences one NUM_WAYS-way cache set built from way instances.
- Accepts one CPU request at a time and performs a parallel tag lookup.
- On a hit, drives the hit way's access/write strobes.
- On a miss, picks a victim by validity/expiry/age, writes it back to memory if dirty, refills, allocates and responds.
- Sits between the CPU request port, the way array and the next-level memory port.

Parameters:
- COUNTER_WIDTH, 8, width of the way age counters.
- NUM_WAYS, 4, number of ways in the set (≥2).
- DATA_WIDTH, 32, data word width; each way holds one word.
- BLOCK_SIZE, 32, block size in bytes. OFFSET_WIDTH = $clog2(BLOCK_SIZE).
- ADDRESS_WIDTH, 32, address width. TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- reqValid/reqReady  in/out  1/1  CPU request handshake.
- reqWrite  in  1  1 = write, 0 = read.
- reqAddr  in  ADDRESS_WIDTH  request address; tag = reqAddr[ADDRESS_WIDTH-1:OFFSET_WIDTH].
- reqWData  in  DATA_WIDTH  write data.
- respValid/respReady  out/in  1/1  response handshake.
- respRData  out  DATA_WIDTH  read data (the written value for writes).
- respHit  out  1  1 = the request hit.
- errMultiHit  out  1  one-cycle pulse when more than one way matches.
- wayTag  in  NUM_WAYS*TAG_WIDTH  per-way tag, packed with way 0 in the LSBs.
- wayValid, wayDirty, wayExpired  in  NUM_WAYS each  per-way state.
- wayAge  in  NUM_WAYS*COUNTER_WIDTH  per-way age.
- wayDataOut  in  NUM_WAYS*DATA_WIDTH  per-way data.
- wayWEn, wayAllocate, wayAccessed  out  NUM_WAYS each  one-hot per-way strobes.
- wayDataIn  out  DATA_WIDTH  data to the way.
- wayAddress  out  ADDRESS_WIDTH  address presented on allocate.
- accessedWayAge  out  COUNTER_WIDTH  age of the accessed way, broadcast to all ways.
- memReqValid/memReqReady  out/in  1/1  memory request handshake.
- memReqWrite  out  1  1 = write-back, 0 = refill read.
- memReqAddr  out  ADDRESS_WIDTH  memory address.
- memReqWData  out  DATA_WIDTH  write-back data.
- memRespValid  in  1  refill data valid.
- memRespRData  in  DATA_WIDTH  refill data.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset forces state IDLE and all outputs 0, including reqReady.
  - Reset during any state abandons the request; an outstanding memReqValid drops immediately.
- IDLE:
  - reqReady = 1.
  - reqValid & reqReady latches reqWrite/reqAddr/reqWData; next state LOOKUP.
- LOOKUP (exactly 1 cycle): hit = wayValid[i] & (wayTag[i] == latched tag).
  - Multiple hits: lowest index is used; errMultiHit pulses.
  - Hit: wayAccessed[h] = 1 and accessedWayAge = wayAge[h] for this cycle.
    - Write: also wayWEn[h] = 1, wayDataIn = reqWData; captured rdata = reqWData.
    - Read: captured rdata = wayDataOut[h].
    - respHit = 1; next state RESP.
  - Miss: victim selected in priority order:
    - lowest-index invalid way;
    - else lowest-index way with wayExpired;
    - else the way with maximum wayAge (ties go to the lowest index).
    - Victim index is latched.
    - Victim valid & dirty: next state WB.
    - Else, write miss: next state ALLOC (a full-word write needs no refill).
    - Else, read miss: next state FILL.
- WB:
  - memReqValid = 1, memReqWrite = 1.
  - memReqAddr = {wayTag[v], OFFSET_WIDTH'0}; memReqWData = wayDataOut[v].
  - All held stable until memReqReady. Then: write miss goes to ALLOC, read miss goes to FILL.
- FILL:
  - memReqValid = 1, memReqWrite = 0, memReqAddr = {latched tag, OFFSET_WIDTH'0}.
  - memReqReady → FILL_WAIT.
- FILL_WAIT:
  - On memRespValid, capture memRespRData → ALLOC.
  - memRespValid in any other state is ignored.
- ALLOC (exactly 1 cycle):
  - wayAllocate[v] = wayWEn[v] = wayAccessed[v] = 1.
  - wayAddress = latched reqAddr; accessedWayAge = wayAge[v].
  - wayDataIn = reqWData for a write, else the refill data; captured rdata = wayDataIn.
  - respHit = 0; next state RESP.
- RESP:
  - respValid = 1; respRData and respHit are held.
  - respReady → IDLE.
  - reqReady = 0 in every state other than IDLE, so there is one outstanding request at a time.
- Latency:
  - Hit: accept at edge N, respValid high from edge N+2.
  - Clean read miss with zero-wait memory: respValid at N+5.
- Strobes:
  - All way strobes are one-hot or zero; they are never asserted outside LOOKUP/ALLOC.
  - wayDataIn, wayAddress and accessedWayAge are 0 when no strobe is active.

Test Plan:
- Reset, way0 valid with tag 0x1234, read reqAddr = 0x1234<<5 → wayAccessed = 4'b0001 in LOOKUP; respValid 2 cycles after accept; respRData = wayDataOut[0]; respHit = 1.
- Write hit to way2 with wdata 0xDEADBEEF → single-cycle wayWEn = 4'b0100, wayDataIn = 0xDEADBEEF; respRData = 0xDEADBEEF; no memReqValid.
- Read miss, way1 invalid, others valid → no write-back; FILL addr = {tag, 5'b0}; memRespRData 0xA5A5A5A5 → wayAllocate = 4'b0010; respRData = 0xA5A5A5A5; respHit = 0.
- All valid, ages {3,9,9,1}, none expired, way1 dirty → victim way1; write-back memReqWrite = 1 with addr {wayTag[1], 0}; stall memReqReady 4 cycles with request stable; then refill, then allocate way1.
- Two ways matching the tag → errMultiHit pulses 1 cycle; the lowest index is accessed.
- rst_n low during FILL_WAIT → memReqValid and all outputs 0 asynchronously; a late memRespValid is ignored; the next request is handled normally.
